// File: rtl/decode_stage_pipelined.sv
// Instruction decode stage: field split, register file read, load-use hazard
// detection and a valid/ready ID/EX register. Optional macro DECODE_WB_BYPASS_EN.
module decode_stage_pipelined #(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int IMMWIDTH         = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction,
  input  logic [WIDTH-1:0]            pcIn,
  input  logic                        flush,
  input  logic                        exIsLoad,
  input  logic [ADDRESSWIDTH-1:0]     exDest,
  input  logic                        wbEnable,
  input  logic [ADDRESSWIDTH-1:0]     wbAddress,
  input  logic [WIDTH-1:0]            wbData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [OPCODEWIDTH-1:0]      opcode,
  output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
  output logic [ADDRESSWIDTH-1:0]     reg1Address,
  output logic [ADDRESSWIDTH-1:0]     reg2Address,
  output logic [WIDTH-1:0]            reg1Content,
  output logic [WIDTH-1:0]            reg2Content,
  output logic [WIDTH-1:0]            inmediate,
  output logic                        hazardStall
);

  localparam int I = INSTRUCTIONWIDTH;
  localparam int O = OPCODEWIDTH;
  localparam int A = ADDRESSWIDTH;
  localparam logic [A-1:0] PC_REG = A'(REGNUM - 1);

  logic [O-1:0]     dec_opcode;
  logic [A-1:0]     dec_rd;
  logic [A-1:0]     dec_rs1;
  logic [A-1:0]     dec_rs2;
  logic [WIDTH-1:0] dec_imm;

  assign dec_opcode = instruction[I-1 -: O];
  assign dec_rd     = instruction[I-O-1 -: A];
  assign dec_rs1    = instruction[I-O-A-1 -: A];
  assign dec_rs2    = instruction[I-O-2*A-1 -: A];
  assign dec_imm    = WIDTH'(instruction[IMMWIDTH-1:0]);

  // Only REGNUM-1 entries are storage; the top address is the PC alias.
  logic [WIDTH-1:0] rf [REGNUM-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGNUM - 1; i++) rf[i] <= '0;
    end else if (wbEnable && wbAddress != PC_REG) begin
      for (int i = 0; i < REGNUM - 1; i++) begin
        if (wbAddress == A'(i)) rf[i] <= wbData;
      end
    end
  end

  logic [WIDTH-1:0] rf_rd1;
  logic [WIDTH-1:0] rf_rd2;

  always_comb begin
    rf_rd1 = '0;
    rf_rd2 = '0;
    for (int i = 0; i < REGNUM - 1; i++) begin
      if (dec_rs1 == A'(i)) rf_rd1 = rf[i];
      if (dec_rs2 == A'(i)) rf_rd2 = rf[i];
    end
  end

  logic wb_hit1;
  logic wb_hit2;
  logic load_hit;
  logic stall_cause;
  logic [WIDTH-1:0] rd1_data;
  logic [WIDTH-1:0] rd2_data;

  assign wb_hit1  = wbEnable && (wbAddress != PC_REG) && (wbAddress == dec_rs1);
  assign wb_hit2  = wbEnable && (wbAddress != PC_REG) && (wbAddress == dec_rs2);
  // An EX load targeting the PC alias still stalls; cheaper than qualifying it.
  assign load_hit = exIsLoad && ((exDest == dec_rs1) || (exDest == dec_rs2));

`ifdef DECODE_WB_BYPASS_EN
  assign stall_cause = load_hit;
  assign rd1_data = (dec_rs1 == PC_REG) ? pcIn : (wb_hit1 ? wbData : rf_rd1);
  assign rd2_data = (dec_rs2 == PC_REG) ? pcIn : (wb_hit2 ? wbData : rf_rd2);
`else
  // Without forwarding, wait one cycle for the write to land in the file.
  assign stall_cause = load_hit || wb_hit1 || wb_hit2;
  assign rd1_data = (dec_rs1 == PC_REG) ? pcIn : rf_rd1;
  assign rd2_data = (dec_rs2 == PC_REG) ? pcIn : rf_rd2;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side. ID/EX may take a new word when empty or being drained
  // (advance); fetch is told ready whenever advance holds and no hazard,
  // even under flush, so a flushed word is consumed and dropped.
  logic advance;

  assign hazardStall = inValid && stall_cause && !flush;
  assign advance     = !outValid || outReady;
  assign inReady     = advance && !hazardStall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outValid              <= 1'b0;
      opcode                <= '0;
      regDestinationAddress <= '0;
      reg1Address           <= '0;
      reg2Address           <= '0;
      reg1Content           <= '0;
      reg2Content           <= '0;
      inmediate             <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (advance) begin
      if (hazardStall) begin
        outValid <= 1'b0;
      end else begin
        outValid <= inValid;
        if (inValid) begin
          opcode                <= dec_opcode;
          regDestinationAddress <= dec_rd;
          reg1Address           <= dec_rs1;
          reg2Address           <= dec_rs2;
          reg1Content           <= rd1_data;
          reg2Content           <= rd2_data;
          inmediate             <= dec_imm;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: a spec-level scoreboard plus
// directed scenario tasks; honours DECODE_WB_BYPASS_EN when defined.
module tb_decode_stage_pipelined;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [23:0] instruction;
  logic [31:0] pcIn;
  logic        flush;
  logic        exIsLoad;
  logic [3:0]  exDest;
  logic        wbEnable;
  logic [3:0]  wbAddress;
  logic [31:0] wbData;
  logic        outValid;
  logic        outReady;
  logic [3:0]  opcode;
  logic [3:0]  regDestinationAddress;
  logic [3:0]  reg1Address;
  logic [3:0]  reg2Address;
  logic [31:0] reg1Content;
  logic [31:0] reg2Content;
  logic [31:0] inmediate;
  logic        hazardStall;

  decode_stage_pipelined dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .instruction(instruction), .pcIn(pcIn), .flush(flush),
    .exIsLoad(exIsLoad), .exDest(exDest), .wbEnable(wbEnable),
    .wbAddress(wbAddress), .wbData(wbData), .outValid(outValid),
    .outReady(outReady), .opcode(opcode),
    .regDestinationAddress(regDestinationAddress), .reg1Address(reg1Address),
    .reg2Address(reg2Address), .reg1Content(reg1Content),
    .reg2Content(reg2Content), .inmediate(inmediate), .hazardStall(hazardStall)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [111:0] exp_q[$];
  logic [31:0]  model_rf [16];
  logic         m_ov;
  logic         nxt_ov;
  logic         last_acc;
  logic [3:0]   s1, s2;
  logic         hz, adv, er, acc;
  logic [111:0] got, item;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) model_rf[i] <= '0;
    end else if (wbEnable && wbAddress != 4'hF) begin
      model_rf[wbAddress] <= wbData;
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) m_ov <= 1'b0;
    else        m_ov <= nxt_ov;
  end

  function automatic logic [31:0] opval(input logic [3:0] a);
    if (a == 4'hF) return pcIn;
`ifdef DECODE_WB_BYPASS_EN
    if (wbEnable && wbAddress == a) return wbData;
`endif
    return model_rf[a];
  endfunction

  // Per-cycle checker and scoreboard, evaluated on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      nxt_ov   = 1'b0;
      last_acc = 1'b0;
    end else begin
      s1  = instruction[15:12];
      s2  = instruction[11:8];
      hz  = inValid && exIsLoad && (exDest == s1 || exDest == s2) && !flush;
`ifndef DECODE_WB_BYPASS_EN
      hz  = hz || (inValid && wbEnable && wbAddress != 4'hF &&
                   (wbAddress == s1 || wbAddress == s2) && !flush);
`endif
      adv = !m_ov || outReady;
      er  = adv && !hz;
      checks++;
      if (hazardStall !== hz) begin errors++; $display("FAIL cyc_hazard got=%b exp=%b t=%0t", hazardStall, hz, $time); end
      checks++;
      if (inReady !== er) begin errors++; $display("FAIL cyc_inready got=%b exp=%b t=%0t", inReady, er, $time); end
      checks++;
      if (outValid !== m_ov) begin errors++; $display("FAIL cyc_outvalid got=%b exp=%b t=%0t", outValid, m_ov, $time); end
      if (m_ov && (outReady || flush)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow t=%0t", $time);
        end else begin
          item = exp_q.pop_front();
          if (outReady) begin
            got = {opcode, regDestinationAddress, reg1Address, reg2Address,
                   reg1Content, reg2Content, inmediate};
            checks++;
            if (got !== item) begin errors++; $display("FAIL sb_data got=%h exp=%h t=%0t", got, item, $time); end
          end
        end
      end
      acc = inValid && er && !flush;
      last_acc = acc;
      if (acc) exp_q.push_back({instruction[23:20], instruction[19:16], s1, s2,
                                opval(s1), opval(s2), 16'h0, instruction[15:0]});
      if (flush)    nxt_ov = 1'b0;
      else if (!adv) nxt_ov = m_ov;
      else if (hz)  nxt_ov = 1'b0;
      else          nxt_ov = inValid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    inValid = 1'b0; flush = 1'b0; exIsLoad = 1'b0; exDest = '0;
    wbEnable = 1'b0; wbAddress = '0; wbData = '0; outReady = 1'b1;
  endtask

  task automatic idle(input int n);
    quiet();
    repeat (n) tick();
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    wbEnable = 1'b1; wbAddress = a; wbData = d;
    tick();
    wbEnable = 1'b0;
  endtask

  task automatic send(input logic [23:0] ins, input logic [31:0] pc);
    bit done;
    done = 0;
    inValid = 1'b1; instruction = ins; pcIn = pc;
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      if (last_acc) done = 1;
    end
    inValid = 1'b0;
    if (!done) begin checks++; errors++; $display("FAIL send_timeout instr=%h", ins); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    quiet(); instruction = '0; pcIn = '0;
    repeat (2) tick();
    reset = 1'b1;
    write_reg(4'd3, 32'h77);
    reset = 1'b0;
    exp_q.delete();
    inValid = 1'b1; instruction = 24'h5123AB; pcIn = 32'h10;
    wbEnable = 1'b1; wbAddress = 4'd5; wbData = 32'h55;
    repeat (3) begin
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", outValid); end
      checks++;
      if ({opcode, regDestinationAddress, reg1Address, reg2Address, reg1Content, reg2Content, inmediate} !== 112'h0) begin
        errors++; $display("FAIL rst_outputs got=%h%h%h exp=0", reg1Content, reg2Content, inmediate);
      end
    end
    quiet();
    reset = 1'b1;
    send(24'h013500, 32'h20);
    checks++; if (reg1Content !== 32'h0) begin errors++; $display("FAIL rst_r3 got=%h exp=0", reg1Content); end
    checks++; if (reg2Content !== 32'h0) begin errors++; $display("FAIL rst_r5 got=%h exp=0", reg2Content); end
    idle(2);
  endtask

  task automatic test_basic();
    write_reg(4'd2, 32'h1234);
    send(24'h512300, 32'h40);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", outValid); end
    checks++; if (opcode !== 4'h5) begin errors++; $display("FAIL basic_opcode got=%h exp=5", opcode); end
    checks++; if (regDestinationAddress !== 4'h1) begin errors++; $display("FAIL basic_rd got=%h exp=1", regDestinationAddress); end
    checks++; if (reg1Content !== 32'h1234) begin errors++; $display("FAIL basic_rs1 got=%h exp=1234", reg1Content); end
    checks++; if (inmediate !== 32'h2300) begin errors++; $display("FAIL basic_imm got=%h exp=2300", inmediate); end
    write_reg(4'hF, 32'hBAD);
    send(24'h51F300, 32'h80);
    checks++; if (reg1Content !== 32'h80) begin errors++; $display("FAIL basic_pc got=%h exp=80", reg1Content); end
    idle(2);
  endtask

  task automatic test_load_use();
    exIsLoad = 1'b1; exDest = 4'd2;
    inValid = 1'b1; instruction = 24'h612300; pcIn = 32'h50;
    #1;
    checks++; if (hazardStall !== 1'b1) begin errors++; $display("FAIL lu_hazard got=%b exp=1", hazardStall); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL lu_inready got=%b exp=0", inReady); end
    repeat (2) begin
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", outValid); end
    end
    exIsLoad = 1'b0;
    send(24'h612300, 32'h50);
    checks++; if (outValid !== 1'b1 || reg1Content !== 32'h1234) begin
      errors++; $display("FAIL lu_issue got=%b/%h exp=1/1234", outValid, reg1Content);
    end
    idle(1);
    exIsLoad = 1'b1; exDest = 4'hF;
    inValid = 1'b1; instruction = 24'h61F000;
    #1;
    checks++; if (hazardStall !== 1'b1) begin errors++; $display("FAIL lu_pcdest got=%b exp=1", hazardStall); end
    idle(2);
  endtask

  task automatic test_backpressure();
    send(24'h732F11, 32'h90);
    outReady = 1'b0;
    inValid = 1'b1; instruction = 24'h842222; pcIn = 32'hA0;
    repeat (4) begin
      tick();
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", outValid); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inready got=%b exp=0", inReady); end
      checks++;
      if (opcode !== 4'h7 || reg1Content !== 32'h1234 || reg2Content !== 32'h90 || inmediate !== 32'h2F11) begin
        errors++; $display("FAIL bp_hold got=%h/%h/%h/%h exp=7/1234/90/2f11", opcode, reg1Content, reg2Content, inmediate);
      end
    end
    outReady = 1'b1;
    send(24'h842222, 32'hA0);
    checks++; if (opcode !== 4'h8 || reg2Content !== 32'h1234) begin
      errors++; $display("FAIL bp_next got=%h/%h exp=8/1234", opcode, reg2Content);
    end
    idle(2);
  endtask

  task automatic test_flush();
    inValid = 1'b1; instruction = 24'hA10000; pcIn = 32'hB0; flush = 1'b1;
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL fl_inready got=%b exp=1", inReady); end
    tick();
    quiet();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL fl_drop got=%b exp=0", outValid); end
    exIsLoad = 1'b1; exDest = 4'd2; flush = 1'b1;
    inValid = 1'b1; instruction = 24'hA12000;
    #1;
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL fl_hazard got=%b exp=0", hazardStall); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL fl_hz_inready got=%b exp=1", inReady); end
    tick();
    quiet();
    send(24'hB10000, 32'hC0);
    outReady = 1'b0; flush = 1'b1;
    tick();
    quiet();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL fl_held got=%b exp=0", outValid); end
    idle(2);
  endtask

  task automatic test_same_cycle_wb();
    wbEnable = 1'b1; wbAddress = 4'd4; wbData = 32'hDEAD;
    inValid = 1'b1; instruction = 24'h953400; pcIn = 32'hD0;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL wb_hazard got=%b exp=0", hazardStall); end
    tick();
    wbEnable = 1'b0; inValid = 1'b0;
`else
    checks++; if (hazardStall !== 1'b1) begin errors++; $display("FAIL wb_hazard got=%b exp=1", hazardStall); end
    tick();
    wbEnable = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL wb_bubble got=%b exp=0", outValid); end
    tick();
    inValid = 1'b0;
`endif
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL wb_valid got=%b exp=1", outValid); end
    checks++; if (reg2Content !== 32'hDEAD) begin errors++; $display("FAIL wb_rs2 got=%h exp=dead", reg2Content); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      inValid     = ($urandom_range(0, 3) != 0);
      instruction = 24'($urandom);
      pcIn        = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      exIsLoad    = ($urandom_range(0, 3) == 0);
      exDest      = 4'($urandom_range(0, 15));
      wbEnable    = ($urandom_range(0, 1) == 1);
      wbAddress   = 4'($urandom_range(0, 15));
      wbData      = $urandom;
      outReady    = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_backpressure();
    test_flush();
    test_same_cycle_wb();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
